// File: rtl/bf_pkg.sv
// Shared types for the Brainfuck core: opcode encoding and fetch FSM states.
package bf_pkg;

  // 3-bit opcode as stored in the program ROM.
  typedef enum logic [2:0] {
    IN   = 3'd0,
    OUT  = 3'd1,
    BACK = 3'd2,
    IF   = 3'd3,
    MOVL = 3'd4,
    MOVR = 3'd5,
    DEC  = 3'd6,
    INC  = 3'd7
  } opcode_t;

  // Fetch sequencer states.
  // RUN  : offering opcodes to the execute unit
  // SKIP : scanning forward past a loop whose entry test found a zero cell
  // HALT : program ran off the end of the ROM
  // ERR  : bracket mismatch or return-stack overflow
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    SKIP = 2'd1,
    HALT = 2'd2,
    ERR  = 2'd3
  } fetch_state_t;

  localparam int DEFAULT_ADDR_W      = 10;
  localparam int DEFAULT_STACK_DEPTH = 16;

  // True for the two control-flow opcodes that the fetch unit resolves itself.
  function automatic logic is_bracket(input opcode_t op);
    return (op == IF) || (op == BACK);
  endfunction

endpackage

// File: rtl/bf_loop_stack.sv
// Loop-return LIFO. The top entry lives in a register so it is readable in the
// same cycle; the entries underneath live in an array read through a
// registered port that always prefetches the entry just below the top.
module bf_loop_stack
  import bf_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SP_W  = $clog2(STACK_DEPTH) + 1;

  // Entries 0 .. sp-2 (counted from the bottom); entry sp-1 is top_reg.
  logic [ADDR_W-1:0] mem [STACK_DEPTH];

  logic [SP_W-1:0]   sp_reg;
  logic [SP_W-1:0]   sp_next;
  logic [ADDR_W-1:0] top_reg;
  logic [ADDR_W-1:0] below_reg;
  logic              do_push;
  logic              do_pop;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  assign empty = (sp_reg == '0);
  assign full  = (sp_reg == SP_W'(STACK_DEPTH));
  assign top   = top_reg;

  // Overflow/underflow requests are ignored here; the sequencer flags them.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;

  // Old top spills into the array at its own depth index.
  assign wr_idx = IDX_W'(sp_reg - SP_W'(1));
  // Prefetch address: the entry that will sit just below the top next cycle.
  assign rd_idx = IDX_W'(sp_next - SP_W'(2));

  // Next stack pointer.
  always_comb begin
    sp_next = sp_reg;
    if (do_push) begin
      sp_next = sp_reg + SP_W'(1);
    end else if (do_pop) begin
      sp_next = sp_reg - SP_W'(1);
    end
  end

  // Array write port: spill the current top when pushing onto a non-empty stack.
  always_ff @(posedge clk) begin
    if (do_push && !empty) begin
      mem[wr_idx] <= top_reg;
    end
  end

  // Stack pointer, top register and registered below-top prefetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_reg    <= '0;
      top_reg   <= '0;
      below_reg <= '0;
    end else begin
      sp_reg <= sp_next;
      if (do_push) begin
        top_reg   <= din;
        // The spilled top is being written this edge, so bypass the array.
        below_reg <= top_reg;
      end else begin
        if (do_pop) begin
          top_reg <= below_reg;
        end
        below_reg <= mem[rd_idx];
      end
    end
  end

endmodule

// File: rtl/bf_fetch.sv
// Instruction fetch/sequencer: drives the ROM address, offers opcodes to the
// execute unit over valid/ready, and resolves [ and ] itself using the loop
// return stack (taken loops) and a depth counter (skipped loops).
module bf_fetch
  import bf_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [2:0]        rom_code,
  input  logic              rom_overrun,
  output logic              ins_valid,
  output logic [2:0]        ins_code,
  input  logic              ins_ready,
  input  logic              cell_zero,
  output logic              halted,
  output logic              stack_err
);

  fetch_state_t      state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] depth_reg;
  logic              halted_reg;
  logic              stack_err_reg;

  opcode_t           op;
  logic [ADDR_W-1:0] pc_inc;
  logic              accept;
  logic              stack_push;
  logic              stack_pop;
  logic [ADDR_W-1:0] stack_top;
  logic              stack_empty;
  logic              stack_full;

  assign op       = opcode_t'(rom_code);
  assign pc_inc   = pc_reg + ADDR_W'(1);
  assign rom_addr = pc_reg;
  assign ins_code = rom_code;
  assign halted   = halted_reg;
  assign stack_err = stack_err_reg;

  // Offer only in RUN with a real opcode under the PC; reset masks it at once.
  assign ins_valid = (state_reg == RUN) && !rom_overrun && !rst;
  assign accept    = ins_valid && ins_ready;

  // Taken loop entry records its own address; exiting a loop drops it.
  assign stack_push = accept && is_bracket(op) && (op == IF) && !cell_zero && !stack_full;
  assign stack_pop  = accept && (op == BACK) && cell_zero && !stack_empty;

  bf_loop_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (stack_push),
    .pop   (stack_pop),
    .din   (pc_reg),
    .top   (stack_top),
    .empty (stack_empty),
    .full  (stack_full)
  );

  // Sequencer FSM with PC, skip-depth counter and sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RUN;
      pc_reg        <= '0;
      depth_reg     <= '0;
      halted_reg    <= 1'b0;
      stack_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (rom_overrun) begin
            state_reg  <= HALT;
            halted_reg <= 1'b1;
          end else if (ins_ready) begin
            case (op)
              IF: begin
                if (cell_zero) begin
                  // Loop body is skipped; we are already one bracket deep.
                  depth_reg <= ADDR_W'(1);
                  pc_reg    <= pc_inc;
                  state_reg <= SKIP;
                end else if (stack_full) begin
                  state_reg     <= ERR;
                  stack_err_reg <= 1'b1;
                end else begin
                  pc_reg <= pc_inc;
                end
              end
              BACK: begin
                if (stack_empty) begin
                  state_reg     <= ERR;
                  stack_err_reg <= 1'b1;
                end else if (!cell_zero) begin
                  // Jump straight into the body; the [ is not re-tested.
                  pc_reg <= stack_top + ADDR_W'(1);
                end else begin
                  pc_reg <= pc_inc;
                end
              end
              default: begin
                pc_reg <= pc_inc;
              end
            endcase
          end
        end
        SKIP: begin
          if (rom_overrun) begin
            // Reached the end while still inside an unmatched [.
            state_reg     <= ERR;
            stack_err_reg <= 1'b1;
          end else begin
            pc_reg <= pc_inc;
            if (op == IF) begin
              depth_reg <= depth_reg + ADDR_W'(1);
            end else if (op == BACK) begin
              if (depth_reg == ADDR_W'(1)) begin
                depth_reg <= '0;
                state_reg <= RUN;
              end else begin
                depth_reg <= depth_reg - ADDR_W'(1);
              end
            end
          end
        end
        default: begin
          // HALT and ERR hold everything until reset.
          state_reg <= state_reg;
        end
      endcase
    end
  end

endmodule
